// File: rtl/ipf_lcu_feeder.sv
// Upstream feeder for the IPF filter: walks a 128x128 frame in LCU order, fetches
// per-LCU parameters and streams pixels through a two-entry (output + skid) buffer.
module ipf_lcu_feeder #(
  parameter int IMG_W  = 128,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        cfg_lcu_size,
  output logic              img_rd,
  output logic [ADDR_W-1:0] img_addr,
  input  logic [7:0]        img_data,
  output logic              par_rd,
  output logic [5:0]        par_addr,
  input  logic [23:0]       par_data,
  input  logic              busy,
  output logic              in_en,
  output logic [7:0]        din,
  output logic [1:0]        ipf_type,
  output logic [4:0]        ipf_band_pos,
  output logic              ipf_wo_class,
  output logic [15:0]       ipf_offset,
  output logic [2:0]        lcu_x,
  output logic [2:0]        lcu_y,
  output logic [1:0]        lcu_size,
  output logic              done
);

  localparam int COORD_W = $clog2(IMG_W);

  typedef enum logic [2:0] {
    S_IDLE, S_PARAM, S_PWAIT, S_STREAM, S_DRAIN, S_DONE
  } state_t;

  state_t       state;
  logic [2:0]   nx, ny;          // LCU being fetched/streamed
  logic [5:0]   r, c;            // next pixel to read inside the LCU
  logic [5:0]   smax;
  logic [2:0]   nmax;
  logic [2:0]   shamt;
  logic [COORD_W-1:0] row, col;
  logic         rd_q;            // a read issued last cycle returns data now
  logic         skid_v;
  logic [7:0]   skid_d;
  logic         acc;
  logic         last_acc;
  logic [1:0]   occ;

  always_comb begin
    smax = 6'd63;
    nmax = 3'd1;
    case (lcu_size)
      2'd0: begin smax = 6'd15; nmax = 3'd7; end
      2'd1: begin smax = 6'd31; nmax = 3'd3; end
      default: ;
    endcase
  end

  assign shamt    = 3'd4 + {1'b0, lcu_size};
  assign row      = (COORD_W'(ny) << shamt) + COORD_W'(r);
  assign col      = (COORD_W'(nx) << shamt) + COORD_W'(c);
  assign img_addr = {row, col};
  assign par_addr = ({3'b000, ny} << (2'd3 - lcu_size)) | {3'b000, nx};

  assign acc      = in_en & ~busy;
  // Pixels held plus the one landing now, minus the one leaving: room for one more read?
  assign occ      = {1'b0, in_en} + {1'b0, skid_v} + {1'b0, rd_q} - {1'b0, acc};
  assign img_rd   = (state == S_STREAM) && (occ < 2'd2);
  // Only the final pixel of an LCU leaves with nothing behind it once reads have stopped.
  assign last_acc = acc && !skid_v && !rd_q;

  // NOTE: sequential state uses non-blocking assignments and the reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      nx           <= '0;
      ny           <= '0;
      r            <= '0;
      c            <= '0;
      lcu_size     <= '0;
      par_rd       <= 1'b0;
      done         <= 1'b0;
      ipf_type     <= '0;
      ipf_band_pos <= '0;
      ipf_wo_class <= 1'b0;
      ipf_offset   <= '0;
      lcu_x        <= '0;
      lcu_y        <= '0;
    end else begin
      par_rd <= 1'b0;
      done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            lcu_size <= (cfg_lcu_size == 2'd3) ? 2'd2 : cfg_lcu_size;
            nx       <= '0;
            ny       <= '0;
            r        <= '0;
            c        <= '0;
            lcu_x    <= '0;
            lcu_y    <= '0;
            par_rd   <= 1'b1;
            state    <= S_PARAM;
          end
        end
        S_PARAM: state <= S_PWAIT;
        S_PWAIT: begin
          ipf_type     <= par_data[23:22];
          ipf_band_pos <= par_data[21:17];
          ipf_wo_class <= par_data[16];
          ipf_offset   <= par_data[15:0];
          lcu_x        <= nx;
          lcu_y        <= ny;
          state        <= S_STREAM;
        end
        S_STREAM: begin
          if (img_rd) begin
            if (c == smax) begin
              c <= '0;
              if (r == smax) begin
                r     <= '0;
                state <= S_DRAIN;
              end else begin
                r <= r + 6'd1;
              end
            end else begin
              c <= c + 6'd1;
            end
          end
        end
        S_DRAIN: begin
          if (last_acc) begin
            if (nx == nmax) begin
              nx <= '0;
              if (ny == nmax) begin
                done  <= 1'b1;
                state <= S_DONE;
              end else begin
                ny     <= ny + 3'd1;
                par_rd <= 1'b1;
                state  <= S_PARAM;
              end
            end else begin
              nx     <= nx + 3'd1;
              par_rd <= 1'b1;
              state  <= S_PARAM;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output register plus skid entry; the skid is always older than returning data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_q   <= 1'b0;
      in_en  <= 1'b0;
      din    <= '0;
      skid_v <= 1'b0;
      skid_d <= '0;
    end else begin
      rd_q <= img_rd;
      if (!in_en || !busy) begin
        if (skid_v) begin
          din    <= skid_d;
          in_en  <= 1'b1;
          skid_v <= rd_q;
          skid_d <= img_data;
        end else if (rd_q) begin
          din   <= img_data;
          in_en <= 1'b1;
        end else begin
          in_en <= 1'b0;
        end
      end else if (rd_q) begin
        skid_v <= 1'b1;
        skid_d <= img_data;
      end
    end
  end

endmodule
